// File: rtl/demux2_stream.sv
// 1-to-2 stream demultiplexer: each input beat is steered by a select bit into one of two
// independent output FIFOs, so a stalled consumer only blocks beats bound for its own side.
module demux2_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [WIDTH-1:0]           in_data_i,
    input  logic                       in_sel_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic [WIDTH-1:0]           out1_data_o,
    output logic                       out1_valid_o,
    input  logic                       out1_ready_i,
    output logic [WIDTH-1:0]           out2_data_o,
    output logic                       out2_valid_o,
    input  logic                       out2_ready_i,
    output logic [$clog2(DEPTH):0]     count1_o,
    output logic [$clog2(DEPTH):0]     count2_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [PtrW-1:0]  wr_q  [2];
    logic [PtrW-1:0]  wr_d  [2];
    logic [PtrW-1:0]  rd_q  [2];
    logic [PtrW-1:0]  rd_d  [2];
    logic [CntW-1:0]  cnt_q [2];
    logic [CntW-1:0]  cnt_d [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_ready;

    assign out_ready = {out2_ready_i, out1_ready_i};

    // A full FIFO refuses its beat even if it pops this edge: no pass-through when full.
    assign in_ready_o = in_sel_i ? (cnt_q[1] != Full) : (cnt_q[0] != Full);

    always_comb begin
        for (int f = 0; f < 2; f++) begin
            push[f]  = in_valid_i && in_ready_o && (in_sel_i == 1'(f));
            pop[f]   = (cnt_q[f] != '0) && out_ready[f];
            wr_d[f]  = push[f] ? wr_q[f] + 1'b1 : wr_q[f];
            rd_d[f]  = pop[f] ? rd_q[f] + 1'b1 : rd_q[f];
            cnt_d[f] = cnt_q[f] + CntW'(push[f]) - CntW'(pop[f]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int f = 0; f < 2; f++) begin
                wr_q[f]  <= '0;
                rd_q[f]  <= '0;
                cnt_q[f] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[f][i] <= '0;
                end
            end
        end else begin
            for (int f = 0; f < 2; f++) begin
                if (push[f]) begin
                    mem_q[f][wr_q[f]] <= in_data_i;
                end
                wr_q[f]  <= wr_d[f];
                rd_q[f]  <= rd_d[f];
                cnt_q[f] <= cnt_d[f];
            end
        end
    end

    assign out1_data_o  = mem_q[0][rd_q[0]];
    assign out2_data_o  = mem_q[1][rd_q[1]];
    assign out1_valid_o = (cnt_q[0] != '0);
    assign out2_valid_o = (cnt_q[1] != '0);
    assign count1_o     = cnt_q[0];
    assign count2_o     = cnt_q[1];

endmodule

// File: doc/demux2_stream.md
Name: demux2_stream

Overview:
- 1-to-2 stream demultiplexer with per-output buffering. It is the steering counterpart to the 2:1 data select in the ALU datapath.
- One 8-bit input stream with valid/ready handshake. Each beat is routed by a sideband select bit to one of two output streams.
- Each output has its own FIFO, so a stalled consumer on one side does not block beats bound for the other side once they are queued.

Parameters:
WIDTH, 8, data width of input and both outputs
DEPTH, 4, entries per output FIFO; power of 2, minimum 2

Ports:
Clk  input  1  clock; all state updates on rising edge
Reset  input  1  asynchronous, active-high reset
InData  input  WIDTH  input beat payload
InSel  input  1  route of the current beat: 0 to output 1, 1 to output 2
InValid  input  1  InData/InSel hold a valid beat
InReady  output  1  block accepts the beat this cycle
Out1Data  output  WIDTH  head of FIFO 1
Out1Valid  output  1  FIFO 1 non-empty
Out1Ready  input  1  consumer 1 takes head this cycle
Out2Data  output  WIDTH  head of FIFO 2
Out2Valid  output  1  FIFO 2 non-empty
Out2Ready  input  1  consumer 2 takes head this cycle
Count1  output  log2(DEPTH)+1  occupancy of FIFO 1
Count2  output  log2(DEPTH)+1  occupancy of FIFO 2

Behaviour:
- Reset (async assert, any time):
  - pointers, counts and storage clear to 0.
  - Out1Valid = Out2Valid = 0; Out1Data = Out2Data = 0; Count1 = Count2 = 0.
  - Queued beats are discarded, including on mid-stream reset.
- InReady is combinational:
  - InReady = (InSel == 0) ? (Count1 != DEPTH) : (Count2 != DEPTH).
  - It depends on InSel, so the source must hold InSel stable with InValid.
- Accept (push):
  - Occurs when InValid && InReady at a rising edge. InData is written to the selected FIFO tail.
  - That FIFO's tail pointer advances mod DEPTH and its count increments.
- Pop:
  - Occurs when OutxValid && OutxReady at a rising edge. Head pointer advances mod DEPTH and count decrements.
  - OutxReady is ignored while OutxValid = 0.
- OutxValid = (Countx != 0). OutxData is a combinational read of storage at the head pointer, registered storage only.
- Latency:
  - A beat accepted at edge k is visible on OutxData with OutxValid = 1 from just after edge k.
  - The earliest pop is at edge k+1.
  - No same-cycle input-to-output bypass.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
  - An empty FIFO can push but cannot pop that edge.
- Full FIFO:
  - InReady = 0 for beats targeting it, even if that FIFO pops in the same cycle. There is no pass-through when full.
  - Beats targeting the other FIFO are unaffected.
- Ordering:
  - Per-output order equals input acceptance order for that output.
  - No ordering between outputs.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Count distinguishes full from empty.
- The two FIFOs are fully independent apart from the shared input port. At most one push per edge in total.
- InData/InSel are don't-care when InValid = 0. A not-accepted beat is simply held by the source; no state changes.

Test Plan:
- Reset then idle -> Out1Valid = Out2Valid = 0, Count1 = Count2 = 0, InReady = 1 for InSel = 0 and 1.
- Push 0x11 (Sel 0), 0x22 (Sel 1), 0x33 (Sel 0) with both OutxReady = 1:
  - Out1 sees 0x11 then 0x33; Out2 sees 0x22.
  - Each appears exactly one edge after acceptance.
- Out1Ready = 0; push 0xA0..0xA3 with Sel 0:
  - Count1 reaches 4 and InReady = 0 for Sel 0.
  - A Sel 1 beat 0xB0 is still accepted and Out2Data = 0xB0.
- FIFO 1 full, assert Out1Ready for 1 cycle while offering Sel 0 beat 0xC0:
  - No accept that edge; Count1 = 3.
  - Next edge accepts 0xC0.
  - Drain order is 0xA1, 0xA2, 0xA3, 0xC0.
- Continuous stream of 10 Sel 0 beats 0x00..0x09 with Out1Ready = 1:
  - Steady-state push and pop every edge; Count1 stays 1.
  - Output order is 0x00..0x09 across pointer wrap.
- Fill FIFO 2 with 3 beats, pulse Reset asynchronously mid-cycle:
  - Out2Valid drops immediately and Count2 = 0.
  - The first post-reset beat 0x5A (Sel 1) appears on Out2Data.
